// File: rtl/lgn_pkg.sv
// Shared types and sizing helpers for the logic-gate-network framing controller.
package lgn_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    RECV,
    EVAL,
    SEND,
    WAIT_TX
  } lgn_state_e;

  function automatic int unsigned out_bytes(input int unsigned net_out_w);
    return (net_out_w + BYTE_W - 1) / BYTE_W;
  endfunction

  // Counter width able to index 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lgn_frame_ctrl_if.sv
// UART-side and network-side signal bundle of the framing controller.
interface lgn_frame_ctrl_if #(
  parameter int unsigned NET_IN_W  = 400,
  parameter int unsigned NET_OUT_W = 50
);
  logic [7:0]           rx_byte;
  logic                 rx_valid;
  logic [NET_IN_W-1:0]  net_in;
  logic [NET_OUT_W-1:0] net_out;
  logic [7:0]           tx_byte;
  logic                 tx_start;
  logic                 tx_done;
  logic                 busy;
  logic                 frame_done;
  logic                 timeout_err;
  logic [7:0]           drop_cnt;

  modport master (
    output rx_byte, rx_valid, net_out, tx_done,
    input  net_in, tx_byte, tx_start, busy, frame_done, timeout_err, drop_cnt
  );

  modport slave (
    input  rx_byte, rx_valid, net_out, tx_done,
    output net_in, tx_byte, tx_start, busy, frame_done, timeout_err, drop_cnt
  );
endinterface

// File: rtl/lgn_out_serializer.sv
// Captures the network result left-aligned and emits it MSB byte first,
// one tx_start per byte, advancing only on the transmitter's tx_done.
module lgn_out_serializer
  import lgn_pkg::*;
#(
  parameter int unsigned NET_OUT_W = 50
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 send,
  input  logic                 ack,
  input  logic [NET_OUT_W-1:0] net_out,
  output logic [7:0]           tx_byte,
  output logic                 tx_start,
  output logic                 frame_done,
  output logic                 last_c
);
  localparam int unsigned OUT_BYTES = out_bytes(NET_OUT_W);
  localparam int unsigned OUT_W     = OUT_BYTES * BYTE_W;
  localparam int unsigned PAD       = OUT_W - NET_OUT_W;
  localparam int unsigned OC_W      = cnt_w(OUT_BYTES);

  logic [OUT_W-1:0] out_shreg_q;
  logic [OC_W-1:0]  out_cnt_q;

  assign last_c = (out_cnt_q == OC_W'(OUT_BYTES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      out_shreg_q <= '0;
      out_cnt_q   <= '0;
      tx_byte     <= '0;
      tx_start    <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      tx_start   <= send;
      frame_done <= ack && last_c;
      if (load) begin
        out_shreg_q <= OUT_W'(net_out) << PAD;
        out_cnt_q   <= '0;
      end else if (ack) begin
        out_shreg_q <= out_shreg_q << BYTE_W;
        out_cnt_q   <= out_cnt_q + OC_W'(1);
      end
      // tx_byte only changes when a new byte is launched
      if (send) begin
        tx_byte <= out_shreg_q[OUT_W-1 -: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/lgn_frame_ctrl.sv
// Frame controller: assembles rx bytes into net_in, waits NET_LAT, serialises net_out.
// Optional sync-header qualification is enabled with LGN_SYNC_HDR_EN.
module lgn_frame_ctrl
  import lgn_pkg::*;
#(
  parameter int unsigned NET_IN_W    = 400,
  parameter int unsigned NET_OUT_W   = 50,
  parameter int unsigned NET_LAT     = 1,
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input logic            clk,
  input logic            rst,
  lgn_frame_ctrl_if.slave bus
);
  localparam int unsigned IN_BYTES = NET_IN_W / BYTE_W;
  localparam int unsigned BC_W     = cnt_w(IN_BYTES);
  localparam int unsigned LAT_W    = cnt_w(NET_LAT);
  localparam int unsigned IDLE_W   = cnt_w(TIMEOUT_CYC + 1);

  lgn_state_e          state_q, state_d;
  logic [BC_W-1:0]     byte_cnt_q;
  logic [LAT_W-1:0]    lat_cnt_q;
  logic [IDLE_W-1:0]   idle_cnt_q;
  logic [NET_IN_W-1:0] net_in_q;
  logic [7:0]          drop_cnt_q;
  logic                timeout_err_q;
  logic                busy_q;
  logic                load_c, store_c, expire_c, armed_c, payload_ok_c, last_c;

`ifdef LGN_SYNC_HDR_EN
  logic hdr_seen_q, hdr_c;

  // A seen header arms the timeout even before any payload byte arrives
  assign armed_c      = (byte_cnt_q != '0) || hdr_seen_q;
  assign payload_ok_c = armed_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_seen_q <= 1'b0;
    end else if (hdr_c) begin
      hdr_seen_q <= 1'b1;
    end else if (expire_c || (state_d == EVAL)) begin
      hdr_seen_q <= 1'b0;
    end
  end
`else
  logic unused_sync_c;

  assign armed_c       = (byte_cnt_q != '0);
  assign payload_ok_c  = 1'b1;
  assign unused_sync_c = ^SYNC_BYTE;
`endif

  always_comb begin
    state_d  = state_q;
    load_c   = 1'b0;
    store_c  = 1'b0;
    expire_c = 1'b0;
`ifdef LGN_SYNC_HDR_EN
    hdr_c    = 1'b0;
`endif
    case (state_q)
      RECV: begin
        if (bus.rx_valid) begin
          if (payload_ok_c) begin
            store_c = 1'b1;
            if (byte_cnt_q == BC_W'(IN_BYTES - 1)) state_d = EVAL;
          end
`ifdef LGN_SYNC_HDR_EN
          else if (bus.rx_byte == SYNC_BYTE) begin
            hdr_c = 1'b1;
          end
`endif
        end else if (armed_c && (TIMEOUT_CYC != 0) &&
                     (idle_cnt_q == IDLE_W'(TIMEOUT_CYC - 1))) begin
          expire_c = 1'b1;
        end
      end
      EVAL: begin
        if (lat_cnt_q == LAT_W'(NET_LAT - 1)) begin
          load_c  = 1'b1;
          state_d = SEND;
        end
      end
      SEND:    state_d = WAIT_TX;
      WAIT_TX: if (bus.tx_done) state_d = last_c ? RECV : SEND;
      default: state_d = RECV;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RECV;
      byte_cnt_q    <= '0;
      lat_cnt_q     <= '0;
      idle_cnt_q    <= '0;
      net_in_q      <= '0;
      drop_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_q        <= (state_d != RECV);
      timeout_err_q <= expire_c;

      if (store_c) begin
        for (int unsigned i = 0; i < IN_BYTES; i++) begin
          if (byte_cnt_q == BC_W'(i)) net_in_q[(IN_BYTES-1-i)*BYTE_W +: BYTE_W] <= bus.rx_byte;
        end
        byte_cnt_q <= (state_d == EVAL) ? '0 : byte_cnt_q + BC_W'(1);
      end else if (expire_c) begin
        byte_cnt_q <= '0;
      end

      // Idle counter runs only while a partial frame is pending
      if ((TIMEOUT_CYC == 0) || (state_q != RECV) || bus.rx_valid || !armed_c || expire_c) begin
        idle_cnt_q <= '0;
      end else begin
        idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
      end

      lat_cnt_q <= (state_q == EVAL) ? lat_cnt_q + LAT_W'(1) : '0;

      if (bus.rx_valid && (state_q != RECV) && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  lgn_out_serializer #(
    .NET_OUT_W (NET_OUT_W)
  ) u_ser (
    .clk        (clk),
    .rst        (rst),
    .load       (load_c),
    .send       (state_q == SEND),
    .ack        ((state_q == WAIT_TX) && bus.tx_done),
    .net_out    (bus.net_out),
    .tx_byte    (bus.tx_byte),
    .tx_start   (bus.tx_start),
    .frame_done (bus.frame_done),
    .last_c     (last_c)
  );

  assign bus.net_in      = net_in_q;
  assign bus.drop_cnt    = drop_cnt_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_err_q;

endmodule
